trace_pkt_serializer: RTL

- Consumer end of the core's per-cycle 3-slot instruction trace packet (valid[2:0], insn 3x32, address 3x64, exception/interrupt per slot, shared ecause/tval).
- Captures each non-empty packet into a DEPTH-entry FIFO and emits retired instructions one per handshake, in slot order, to a log/trace port.
- The core cannot be back-pressured, so overflow drops whole packets and flags the drop.

---
 rtl/trace_pkt_serializer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/trace_pkt_serializer.sv
// trace_pkt_serializer
// --------------------
// Consumer end of a 3-slot per-cycle instruction trace packet. Every packet
// with at least one valid slot is captured into a DEPTH-entry FIFO; retired
// instructions are then emitted one per out_valid/out_ready handshake, in
// arrival order and, inside a packet, in slot order (invalid slots skipped).
// The producer cannot be stalled, so a packet that finds no room is dropped
// whole and the sticky overflow flag is raised.
//
// Parameters:
//   DEPTH  FIFO entries in packets (power of two, >= 2)
//
// Ports:
//   clk, rst_l                 clock, asynchronous active-low reset
//   trace_rv_i_*_ip            incoming trace packet (valid/insn/address/
//                              exception/ecause/interrupt/tval)
//   out_valid / out_ready      record handshake
//   out_slot, out_insn, out_addr, out_exception, out_interrupt,
//   out_ecause, out_tval       record fields (ecause/tval zeroed unless the
//                              slot has an exception or interrupt)
//   overflow / overflow_clr    sticky drop flag and its clear
//   drop_cnt                   saturating dropped-packet counter, present
//                              only when RV_TRACE_DROP_CNT_EN is defined
//
// All outputs are decoded from registered state only; there is no
// combinational path from any input to any output.
module trace_pkt_serializer #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_l,
    input  logic [2:0]   trace_rv_i_valid_ip,
    input  logic [95:0]  trace_rv_i_insn_ip,
    input  logic [191:0] trace_rv_i_address_ip,
    input  logic [2:0]   trace_rv_i_exception_ip,
    input  logic [4:0]   trace_rv_i_ecause_ip,
    input  logic [2:0]   trace_rv_i_interrupt_ip,
    input  logic [63:0]  trace_rv_i_tval_ip,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_slot,
    output logic [31:0]  out_insn,
    output logic [63:0]  out_addr,
    output logic         out_exception,
    output logic         out_interrupt,
    output logic [4:0]   out_ecause,
    output logic [63:0]  out_tval,
    output logic         overflow,
    input  logic         overflow_clr
`ifdef RV_TRACE_DROP_CNT_EN
    ,
    output logic [15:0]  drop_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    // Packet storage; the mask holds the slots of an entry not yet emitted.
    logic [95:0]  insn_mem_r   [DEPTH];
    logic [191:0] addr_mem_r   [DEPTH];
    logic [2:0]   exc_mem_r    [DEPTH];
    logic [2:0]   intr_mem_r   [DEPTH];
    logic [4:0]   ecause_mem_r [DEPTH];
    logic [63:0]  tval_mem_r   [DEPTH];
    logic [2:0]   mask_mem_r   [DEPTH];

    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic          overflow_r;

    logic          nonempty_s;
    logic [2:0]    head_mask_s;
    logic [2:0]    sel_onehot_s;
    logic [2:0]    rem_mask_s;
    logic [1:0]    sel_slot_s;
    logic          transfer_s;
    logic          pop_s;
    logic          push_req_s;
    logic          accept_s;
    logic          drop_s;

    // Isolate the lowest set bit of a slot mask (slot0 has priority).
    function automatic logic [2:0] lowest_onehot(input logic [2:0] m);
        logic [2:0] r;
        if (m[0]) begin
            r = 3'b001;
        end else if (m[1]) begin
            r = 3'b010;
        end else if (m[2]) begin
            r = 3'b100;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Head selection, handshake and push/pop/drop decisions.
    always_comb begin
        nonempty_s   = (count_r != {CW{1'b0}});
        head_mask_s  = mask_mem_r[rd_ptr_r];
        sel_onehot_s = lowest_onehot(head_mask_s);
        rem_mask_s   = head_mask_s & ~sel_onehot_s;
        case (sel_onehot_s)
            3'b010:  sel_slot_s = 2'd1;
            3'b100:  sel_slot_s = 2'd2;
            default: sel_slot_s = 2'd0;
        endcase
        transfer_s = nonempty_s & out_ready;
        // The head retires only when its last remaining slot is taken.
        pop_s      = transfer_s & (rem_mask_s == 3'b000);
        push_req_s = (trace_rv_i_valid_ip != 3'b000);
        // A full FIFO still accepts when the head retires in the same cycle.
        accept_s   = push_req_s & ((count_r != FULL_C) | pop_s);
        drop_s     = push_req_s & ~accept_s;
    end

    // Output record decode from the head entry; zero whenever empty.
    always_comb begin
        out_valid     = nonempty_s;
        out_slot      = 2'd0;
        out_insn      = 32'h0000_0000;
        out_addr      = 64'h0000_0000_0000_0000;
        out_exception = 1'b0;
        out_interrupt = 1'b0;
        out_ecause    = 5'd0;
        out_tval      = 64'h0000_0000_0000_0000;
        if (nonempty_s) begin
            out_slot = sel_slot_s;
            case (sel_slot_s)
                2'd0: begin
                    out_insn      = insn_mem_r[rd_ptr_r][31:0];
                    out_addr      = addr_mem_r[rd_ptr_r][63:0];
                    out_exception = exc_mem_r[rd_ptr_r][0];
                    out_interrupt = intr_mem_r[rd_ptr_r][0];
                end
                2'd1: begin
                    out_insn      = insn_mem_r[rd_ptr_r][63:32];
                    out_addr      = addr_mem_r[rd_ptr_r][127:64];
                    out_exception = exc_mem_r[rd_ptr_r][1];
                    out_interrupt = intr_mem_r[rd_ptr_r][1];
                end
                2'd2: begin
                    out_insn      = insn_mem_r[rd_ptr_r][95:64];
                    out_addr      = addr_mem_r[rd_ptr_r][191:128];
                    out_exception = exc_mem_r[rd_ptr_r][2];
                    out_interrupt = intr_mem_r[rd_ptr_r][2];
                end
                default: begin
                    out_insn      = 32'h0000_0000;
                    out_addr      = 64'h0000_0000_0000_0000;
                    out_exception = 1'b0;
                    out_interrupt = 1'b0;
                end
            endcase
            // ecause/tval are shared by the packet; only attribute them to
            // the slot that actually trapped.
            if (out_exception | out_interrupt) begin
                out_ecause = ecause_mem_r[rd_ptr_r];
                out_tval   = tval_mem_r[rd_ptr_r];
            end else begin
                out_ecause = 5'd0;
                out_tval   = 64'h0000_0000_0000_0000;
            end
        end else begin
            out_slot = 2'd0;
        end
    end

    // Packet payload write; payload is qualified by the reset mask array.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            insn_mem_r[wr_ptr_r]   <= trace_rv_i_insn_ip;
            addr_mem_r[wr_ptr_r]   <= trace_rv_i_address_ip;
            exc_mem_r[wr_ptr_r]    <= trace_rv_i_exception_ip;
            intr_mem_r[wr_ptr_r]   <= trace_rv_i_interrupt_ip;
            ecause_mem_r[wr_ptr_r] <= trace_rv_i_ecause_ip;
            tval_mem_r[wr_ptr_r]   <= trace_rv_i_tval_ip;
        end
    end

    // FIFO control: slot masks, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
            overflow_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mask_mem_r[i] <= 3'b000;
            end
        end else begin
            if (transfer_s) begin
                mask_mem_r[rd_ptr_r] <= rem_mask_s;
            end
            // On simultaneous pop+push into a full FIFO wr_ptr == rd_ptr and
            // the new packet's mask must win, so this write comes second.
            if (accept_s) begin
                mask_mem_r[wr_ptr_r] <= trace_rv_i_valid_ip;
                wr_ptr_r             <= wr_ptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (overflow_clr) begin
                overflow_r <= 1'b0;
            end
        end
    end

    assign overflow = overflow_r;

`ifdef RV_TRACE_DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating dropped-packet counter; a drop in the clearing cycle counts.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            drop_cnt_r <= 16'h0000;
        end else if (overflow_clr) begin
            drop_cnt_r <= drop_s ? 16'h0001 : 16'h0000;
        end else if (drop_s && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end
    end

    assign drop_cnt = drop_cnt_r;
`endif

endmodule
